// File: rtl/rm_pkg.sv
// Shared definitions for the RISC machine: instruction field positions,
// one-hot register-select encodings and opcode constants.
package rm_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;

  typedef enum logic [2:0] {
    NSEL_RN = 3'b001,
    NSEL_RD = 3'b010,
    NSEL_RM = 3'b100
  } nsel_t;

  localparam logic [2:0] OPC_ILLEGAL = 3'b000;
  localparam logic [2:0] MOV         = 3'b110;
  localparam logic [2:0] ALU         = 3'b101;
  localparam logic [2:0] LDR         = 3'b011;
  localparam logic [2:0] STR         = 3'b100;
  localparam logic [2:0] HLT         = 3'b111;

endpackage

// File: rtl/reg_sel_mux.sv
// One-hot 3:1 register-number mux; any select that is not exactly one-hot
// yields register 0 so a corrupted select never addresses a random register.
module reg_sel_mux
  import rm_pkg::*;
(
  input  logic [2:0] nsel_i,
  input  logic [2:0] rn_i,
  input  logic [2:0] rd_i,
  input  logic [2:0] rm_i,
  output logic [2:0] sel_o
);

  always_comb begin
    sel_o = 3'b000;
    case (nsel_i)
      NSEL_RN: sel_o = rn_i;
      NSEL_RD: sel_o = rd_i;
      NSEL_RM: sel_o = rm_i;
      default: sel_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/instruction_decoder.sv
// Combinational field decode of the 16-bit instruction word, plus a sticky
// flag that remembers any undefined opcode seen since the last reset.
module instruction_decoder
  import rm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic [2:0]  nsel,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] imm8,
  output logic [15:0] imm5,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        illegal,
  output logic        err_sticky
);

  logic [2:0] regnum;
  logic       err_q;
  logic       err_d;

  assign opcode = in[OPC_MSB:OPC_LSB];
  assign op     = in[OP_MSB:OP_LSB];
  assign ALUop  = in[OP_MSB:OP_LSB];
  // Shift is passed raw; the controller masks it for opcodes that ignore it.
  assign shift  = in[SH_MSB:SH_LSB];

  assign imm8 = {{8{in[7]}}, in[7:0]};
  assign imm5 = {{11{in[4]}}, in[4:0]};

  assign illegal = (in[OPC_MSB:OPC_LSB] == OPC_ILLEGAL);

  reg_sel_mux u_reg_sel_mux (
    .nsel_i (nsel),
    .rn_i   (in[RN_MSB:RN_LSB]),
    .rd_i   (in[RD_MSB:RD_LSB]),
    .rm_i   (in[RM_MSB:RM_LSB]),
    .sel_o  (regnum)
  );

  // Read and write ports share one mux so they can never disagree.
  assign readnum  = regnum;
  assign writenum = regnum;

  assign err_d = err_q | illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed field vectors, sticky-error
// sequences with an expected-value queue, and a random field sweep.
module tb_instruction_decoder;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [2:0]  nsel;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [1:0]  alu_op;
  logic [1:0]  shift;
  logic [15:0] imm8;
  logic [15:0] imm5;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        illegal;
  logic        err_sticky;

  int pass_cnt = 0;
  int total    = 0;

  logic [0:0] exp_q[$];
  logic       exp_err;

  instruction_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .in         (din),
    .nsel       (nsel),
    .opcode     (opcode),
    .op         (op),
    .ALUop      (alu_op),
    .shift      (shift),
    .imm8       (imm8),
    .imm5       (imm5),
    .readnum    (readnum),
    .writenum   (writenum),
    .illegal    (illegal),
    .err_sticky (err_sticky)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] in;
    logic [2:0]  nsel;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rnum;
    logic [15:0] i8;
    logic [15:0] i5;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // driver tasks
  task automatic drive(input logic [15:0] w, input logic [2:0] s);
    din  = w;
    nsel = s;
    #1;
  endtask

  // Drive a word at the falling edge, clock once, then compare err_sticky
  // against the bench's own model of the sticky flag.
  task automatic clock_word(input logic [15:0] w, input string name);
    @(negedge clk);
    din = w;
    #1;
    if (!reset) exp_err = exp_err | (w[15:13] == 3'b000);
    exp_q.push_back(exp_err);
    @(posedge clk);
    #1;
    check(name, {63'd0, err_sticky}, {63'd0, exp_q.pop_front()});
  endtask

  function automatic logic [47:0] ref_pack(input logic [15:0] w, input logic [2:0] s);
    logic [2:0]  r;
    logic [15:0] e8;
    logic [15:0] e5;
    logic [7:0]  low8;
    logic [4:0]  low5;
    low8 = w[7:0];
    low5 = w[4:0];
    e8 = (low8 >= 8'd128) ? (16'hFF00 + {8'd0, low8}) : {8'd0, low8};
    e5 = (low5 >= 5'd16) ? (16'hFFE0 + {11'd0, low5}) : {11'd0, low5};
    if (s == 3'd1)      r = (w >> 8) & 16'h7;
    else if (s == 3'd2) r = (w >> 5) & 16'h7;
    else if (s == 3'd4) r = w & 16'h7;
    else                r = 3'd0;
    ref_pack = {w[15:13], w[12:11], w[12:11], w[4:3], r, r, e8, e5, (w < 16'h2000)};
  endfunction

  initial begin
    vecs[0]  = '{16'hD007, 3'b001, 3'b110, 2'b10, 2'b00, 3'b000, 16'h0007, 16'h0007, 1'b0};
    vecs[1]  = '{16'hAAAA, 3'b010, 3'b101, 2'b01, 2'b01, 3'b101, 16'hFFAA, 16'h000A, 1'b0};
    vecs[2]  = '{16'hAAAA, 3'b001, 3'b101, 2'b01, 2'b01, 3'b010, 16'hFFAA, 16'h000A, 1'b0};
    vecs[3]  = '{16'hAAAA, 3'b100, 3'b101, 2'b01, 2'b01, 3'b010, 16'hFFAA, 16'h000A, 1'b0};
    vecs[4]  = '{16'h00F0, 3'b001, 3'b000, 2'b00, 2'b10, 3'b000, 16'hFFF0, 16'hFFF0, 1'b1};
    vecs[5]  = '{16'h0010, 3'b010, 3'b000, 2'b00, 2'b10, 3'b000, 16'h0010, 16'hFFF0, 1'b1};
    vecs[6]  = '{16'h007F, 3'b010, 3'b000, 2'b00, 2'b11, 3'b011, 16'h007F, 16'hFFFF, 1'b1};
    vecs[7]  = '{16'hFFFF, 3'b000, 3'b111, 2'b11, 2'b11, 3'b000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[8]  = '{16'hFFFF, 3'b011, 3'b111, 2'b11, 2'b11, 3'b000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[9]  = '{16'hFFFF, 3'b111, 3'b111, 2'b11, 2'b11, 3'b000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[10] = '{16'hFFFF, 3'b100, 3'b111, 2'b11, 2'b11, 3'b111, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[11] = '{16'h0080, 3'b010, 3'b000, 2'b00, 2'b00, 3'b100, 16'hFF80, 16'h0000, 1'b1};
    vecs[12] = '{16'h8000, 3'b001, 3'b100, 2'b00, 2'b00, 3'b000, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{16'h6E38, 3'b001, 3'b011, 2'b01, 2'b11, 3'b110, 16'h0038, 16'hFFF8, 1'b0};

    reset   = 1'b1;
    din     = 16'hD000;
    nsel    = 3'b001;
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    check("reset_err_sticky", {63'd0, err_sticky}, 64'd0);

    // Directed field vectors (reset held: fields must not depend on it).
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].in, vecs[i].nsel);
      check($sformatf("v%0d_opcode", i),   {61'd0, opcode},   {61'd0, vecs[i].opc});
      check($sformatf("v%0d_op", i),       {62'd0, op},       {62'd0, vecs[i].op});
      check($sformatf("v%0d_aluop", i),    {62'd0, alu_op},   {62'd0, vecs[i].op});
      check($sformatf("v%0d_shift", i),    {62'd0, shift},    {62'd0, vecs[i].sh});
      check($sformatf("v%0d_readnum", i),  {61'd0, readnum},  {61'd0, vecs[i].rnum});
      check($sformatf("v%0d_writenum", i), {61'd0, writenum}, {61'd0, vecs[i].rnum});
      check($sformatf("v%0d_imm8", i),     {48'd0, imm8},     {48'd0, vecs[i].i8});
      check($sformatf("v%0d_imm5", i),     {48'd0, imm5},     {48'd0, vecs[i].i5});
      check($sformatf("v%0d_illegal", i),  {63'd0, illegal},  {63'd0, vecs[i].ill});
    end

    // Reset held through a clock edge with an illegal word: flag stays clear.
    clock_word(16'h0000, "err_held_in_reset");

    // Release reset away from an edge, then an illegal word sets the flag.
    @(negedge clk);
    reset = 1'b0;
    clock_word(16'h0000, "err_set_on_illegal");
    check("illegal_comb", {63'd0, illegal}, 64'd1);
    clock_word(16'hD000, "err_holds_on_legal");
    clock_word(16'hAAAA, "err_holds_again");

    // Mid-cycle async reset clears without a clock edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("err_async_clear", {63'd0, err_sticky}, 64'd0);
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clock_word(16'hD000, "err_stays_clear_legal");
    clock_word(16'hE000, "err_stays_clear_hlt");
    clock_word(16'h1FFF, "err_set_top_illegal");

    // Random sweep of words against the reference field model, all nsel values.
    for (int k = 0; k < 48; k++) begin
      logic [15:0] w;
      w = 16'($urandom_range(0, 65535));
      for (int s = 0; s < 8; s++) begin
        drive(w, 3'(s));
        check($sformatf("sweep_%04h_nsel%0d", w, s),
              {16'd0, opcode, op, alu_op, shift, readnum, writenum, imm8, imm5, illegal},
              {16'd0, ref_pack(w, 3'(s))});
      end
    end

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
